alu_selftest_driver: RTL and testbench

// Initiator-side companion to the 4-bit ALU: drives its operand/opcode/enable inputs and checks its result/flag outputs.
// On a start pulse it issues every {opcode, b, a} vector once, one per clock, and compares the ALU outputs against an internal golden model.
// It records the error count and the first failing vector index, then reports pass/fail.

---
 rtl/alu_selftest_driver.sv | 180 ++++++++++++++++++
 tb/tb_alu_selftest_driver.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_selftest_driver.sv
// Built-in self test initiator for the small ALU: sweeps every {opcode, b, a} vector once,
// checks each result against a golden model and reports error count, first failing index and pass.
module alu_selftest_driver #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1,
  parameter int ERRW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [2:0]           op_code,
  output logic                 alu_ena,
  input  logic [WIDTH-1:0]     alu_res,
  input  logic                 alu_cb,
  input  logic                 alu_par,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERRW-1:0]      err_count,
  output logic [2*WIDTH+2:0]   first_fail,
  output logic                 fail_seen,
  output logic [1:0]           dbg_state
);

  localparam int IW  = 2*WIDTH + 3;
  localparam int EW  = WIDTH + 2;
  localparam int PW  = 1 + IW + EW;
  localparam int DCW = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            cb_g_q, cb_g_d;
  logic            par_g_q, par_g_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [IW-1:0]   ff_q, ff_d;
  logic            fs_q, fs_d;
  logic [PW-1:0]   pipe_q [LATENCY];
  logic [PW-1:0]   pipe_d [LATENCY];

  logic            accept;
  logic            issue;
  logic [WIDTH-1:0] va, vb, g_res;
  logic [2:0]      vop;
  logic            g_cb;
  logic [EW-1:0]   exp_now;
  logic            due;
  logic [IW-1:0]   due_idx;
  logic [EW-1:0]   due_exp;
  logic            mism;

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign issue  = (state_q == RUN);
  assign va     = idx_q[WIDTH-1:0];
  assign vb     = idx_q[2*WIDTH-1:WIDTH];
  assign vop    = idx_q[IW-1:2*WIDTH];

  // Golden ALU: carry is sticky across logic ops, parity reports the previous vector's result.
  always_comb begin
    g_res = '0;
    g_cb  = cb_g_q;
    case (vop)
      3'd0: {g_cb, g_res} = {1'b0, va} + {1'b0, vb};
      3'd1: {g_cb, g_res} = {1'b0, va} - {1'b0, vb};
      3'd2: g_res = va & vb;
      3'd3: g_res = va | vb;
      3'd4: g_res = va ^ vb;
      3'd5: g_res = ~(va | vb);
      3'd6: g_res = ~va;
      default: g_res = vb;
    endcase
    exp_now = {g_res, g_cb, par_g_q};
  end

  assign due     = pipe_q[LATENCY-1][PW-1];
  assign due_idx = pipe_q[LATENCY-1][PW-2:EW];
  assign due_exp = pipe_q[LATENCY-1][EW-1:0];
  assign mism    = due && ({alu_res, alu_cb, alu_par} != due_exp);

  // Next-state process
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (idx_q == {IW{1'b1}}) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        if (drain_q == DCW'(LATENCY - 1)) state_d = DONE;
        else drain_d = drain_q + 1'b1;
      end
    endcase
  end

  // Checker datapath: golden state, expectation delay line, error bookkeeping.
  always_comb begin
    cb_g_d  = cb_g_q;
    par_g_d = par_g_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fs_d    = fs_q;
    pipe_d[0] = {issue, idx_q, exp_now};
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    if (issue) begin
      cb_g_d  = g_cb;
      par_g_d = ^g_res;
    end
    if (mism) begin
      if (err_q != {ERRW{1'b1}}) err_d = err_q + 1'b1;
      if (!fs_q) begin
        ff_d = due_idx;
        fs_d = 1'b1;
      end
    end
    if (accept) begin
      cb_g_d  = 1'b0;
      par_g_d = 1'b0;
      err_d   = '0;
      ff_d    = '0;
      fs_d    = 1'b0;
      for (int i = 0; i < LATENCY; i++) pipe_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drain_q <= '0;
      cb_g_q  <= 1'b0;
      par_g_q <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      fs_q    <= 1'b0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      cb_g_q  <= cb_g_d;
      par_g_q <= par_g_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fs_q    <= fs_d;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Output process
  always_comb begin
    op_a       = issue ? va  : '0;
    op_b       = issue ? vb  : '0;
    op_code    = issue ? vop : '0;
    alu_ena    = (state_q == RUN) || (state_q == DRAIN);
    busy       = alu_ena;
    done       = (state_q == DONE);
    pass       = done && (err_q == '0);
    err_count  = err_q;
    first_fail = ff_q;
    fail_seen  = fs_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_alu_selftest_driver.sv
// Bench for alu_selftest_driver: a registered ALU model with injectable output faults,
// a sweep-level reference of the expected report, and a scoreboard of reports per start.
module tb_alu_selftest_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op_a, op_b, s_op_a, s_op_b;
  logic [2:0]  op_code, s_op_code;
  logic        alu_ena, s_alu_ena;
  logic [3:0]  alu_res;
  logic        alu_cb, alu_par;
  logic        busy, done, pass, fail_seen;
  logic        s_busy, s_done, s_pass, s_fail_seen;
  logic [7:0]  err_count;
  logic [3:0]  s_err_count;
  logic [10:0] first_fail, s_first_fail;
  logic [1:0]  dbg_state, s_dbg_state;

  int fault_mode = 0;
  int total = 0;
  int bad = 0;
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  alu_selftest_driver #(.WIDTH(4), .LATENCY(1), .ERRW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .alu_ena(alu_ena),
    .alu_res(alu_res), .alu_cb(alu_cb), .alu_par(alu_par),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail(first_fail), .fail_seen(fail_seen), .dbg_state(dbg_state)
  );

  // Narrow-counter twin fed the same ALU outputs, to see err_count saturate at 15.
  alu_selftest_driver #(.WIDTH(4), .LATENCY(1), .ERRW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(s_op_a), .op_b(s_op_b), .op_code(s_op_code), .alu_ena(s_alu_ena),
    .alu_res(alu_res), .alu_cb(alu_cb), .alu_par(alu_par),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .first_fail(s_first_fail), .fail_seen(s_fail_seen), .dbg_state(s_dbg_state)
  );

  // ALU model: one-cycle registered result, sticky carry on logic ops, parity of previous result.
  logic [3:0]  res_r;
  logic        cb_r, par_r;
  logic [10:0] vidx_r;
  logic [4:0]  sum5, dif5;
  assign sum5 = {1'b0, op_a} + {1'b0, op_b};
  assign dif5 = {1'b0, op_a} - {1'b0, op_b};

  always @(posedge clk) begin
    if (!alu_ena) begin
      res_r <= 4'd0; cb_r <= 1'b0; par_r <= 1'b0; vidx_r <= 11'd0;
    end else begin
      par_r  <= ^res_r;
      vidx_r <= {op_code, op_b, op_a};
      case (op_code)
        3'd0: begin res_r <= sum5[3:0]; cb_r <= sum5[4]; end
        3'd1: begin res_r <= dif5[3:0]; cb_r <= (op_a < op_b); end
        3'd2: res_r <= op_a & op_b;
        3'd3: res_r <= op_a | op_b;
        3'd4: res_r <= op_a ^ op_b;
        3'd5: res_r <= ~(op_a | op_b);
        3'd6: res_r <= ~op_a;
        default: res_r <= op_b;
      endcase
    end
  end

  assign alu_res = (fault_mode == 3) ? 4'd0 : (res_r ^ {3'b000, (fault_mode == 1 && vidx_r == 11'd5)});
  assign alu_cb  = (fault_mode == 2) ? 1'b0 : cb_r;
  assign alu_par = par_r;

  // Whole-sweep reference: which vectors the faulty ALU gets wrong, packed as the report.
  function automatic logic [24:0] model_report(input int mode);
    logic [3:0] a, b, r, fr;
    logic [2:0] op;
    logic [4:0] t;
    logic c, fc;
    int cnt, first;
    c = 1'b0; cnt = 0; first = 0;
    for (int k = 0; k < 2048; k++) begin
      a = k[3:0]; b = k[7:4]; op = k[10:8];
      case (op)
        3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; end
        3'd1: begin r = a - b; c = (a < b); end
        3'd2: r = a & b;
        3'd3: r = a | b;
        3'd4: r = a ^ b;
        3'd5: r = ~(a | b);
        3'd6: r = ~a;
        default: r = b;
      endcase
      fr = r; fc = c;
      if (mode == 1 && k == 5) fr = r ^ 4'd1;
      if (mode == 2) fc = 1'b0;
      if (mode == 3) fr = 4'd0;
      if (fr != r || fc != c) begin
        if (cnt == 0) first = k;
        cnt++;
      end
    end
    return {(cnt == 0), (cnt != 0), 11'(first),
            (cnt > 255) ? 8'd255 : 8'(cnt), (cnt > 15) ? 4'd15 : 4'(cnt)};
  endfunction

  function automatic logic [24:0] observed();
    return {pass, fail_seen, first_fail, err_count, s_err_count};
  endfunction

  // Drivers: pulse start so that the edge ending cycle 0 samples it; returns in cycle 1.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic step(inout int cyc);
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic wait_done(input int c0, output int done_c, output int last_busy);
    int cyc;
    cyc = c0;
    last_busy = busy ? cyc : 0;
    while (!done && cyc < 3000) begin
      step(cyc);
      if (busy) last_busy = cyc;
    end
    done_c = done ? cyc : -1;
  endtask

  task automatic test_reset();
    total++;
    if ({op_a, op_b, op_code, alu_ena, busy, done, pass, err_count, first_fail, fail_seen, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%0d state=%0d, want all zero", busy, done, err_count, dbg_state);
    end
  endtask

  task automatic test_clean_pass();
    int cyc, dc, lb;
    logic [24:0] e;
    fault_mode = 0;
    exp_q.push_back(model_report(0));
    pulse_start();
    cyc = 1;
    total++;
    if ({busy, alu_ena, op_code, op_b, op_a} !== {1'b1, 1'b1, 11'd0}) begin
      bad++;
      $display("FAIL first_vector: got busy=%b ena=%b vec=%0d, want 1 1 0", busy, alu_ena, {op_code, op_b, op_a});
    end
    while (cyc < 38) step(cyc);
    total++;
    if ({op_code, op_b, op_a} !== 11'd37) begin
      bad++;
      $display("FAIL vector_order: got %0d at cycle 38, want 37", {op_code, op_b, op_a});
    end
    wait_done(cyc, dc, lb);
    total++;
    if (dc != 2050 || lb != 2049) begin
      bad++;
      $display("FAIL sweep_timing: got done at %0d last busy %0d, want 2050 and 2049", dc, lb);
    end
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL clean_report: got %h, want %h", observed(), e);
    end
  endtask

  task automatic test_flip_vector5();
    int dc, lb;
    logic [24:0] e;
    fault_mode = 1;
    exp_q.push_back(model_report(1));
    pulse_start();
    wait_done(1, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (observed() !== e || dc != 2050) begin
      bad++;
      $display("FAIL flip5_report: got %h done@%0d, want %h done@2050", observed(), dc, e);
    end
  endtask

  task automatic test_carry_stuck();
    int dc, lb;
    logic [24:0] e;
    fault_mode = 2;
    exp_q.push_back(model_report(2));
    pulse_start();
    wait_done(1, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL carry_report: got %h, want %h", observed(), e);
    end
    total++;
    if (first_fail !== 11'd31 || pass !== 1'b0) begin
      bad++;
      $display("FAIL carry_first: got first_fail=%0d pass=%b, want 31 0", first_fail, pass);
    end
  endtask

  task automatic test_res_stuck();
    int dc, lb;
    logic [24:0] e;
    fault_mode = 3;
    exp_q.push_back(model_report(3));
    pulse_start();
    wait_done(1, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL stuck_report: got %h, want %h", observed(), e);
    end
    total++;
    if (s_err_count !== 4'd15 || err_count !== 8'd255) begin
      bad++;
      $display("FAIL saturation: got err4=%0d err8=%0d, want 15 255", s_err_count, err_count);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, dc, lb;
    logic [24:0] e;
    fault_mode = 0;
    exp_q.push_back(model_report(0));
    pulse_start();
    cyc = 1;
    while (cyc < 100) step(cyc);
    start = 1'b1;
    step(cyc);
    start = 1'b0;
    total++;
    if ({op_code, op_b, op_a} !== 11'd100 || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start: got vec=%0d busy=%b at cycle 101, want 100 1", {op_code, op_b, op_a}, busy);
    end
    wait_done(cyc, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (dc != 2050 || observed() !== e) begin
      bad++;
      $display("FAIL ignore_start: got done@%0d %h, want done@2050 %h", dc, observed(), e);
    end
  endtask

  task automatic test_restart_from_done();
    int dc, lb;
    logic [24:0] e;
    fault_mode = 1;
    exp_q.push_back(model_report(1));
    pulse_start();
    wait_done(1, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL pre_restart: got %h, want %h", observed(), e);
    end
    fault_mode = 0;
    exp_q.push_back(model_report(0));
    pulse_start();
    total++;
    if ({done, pass, fail_seen, err_count, first_fail, busy} !== {21'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart_clear: got done=%b pass=%b fs=%b err=%0d ff=%0d busy=%b, want 0 0 0 0 0 1",
               done, pass, fail_seen, err_count, first_fail, busy);
    end
    wait_done(1, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (dc != 2050 || observed() !== e) begin
      bad++;
      $display("FAIL restart_report: got done@%0d %h, want done@2050 %h", dc, observed(), e);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, dc, lb;
    logic [24:0] e;
    fault_mode = 0;
    pulse_start();
    cyc = 1;
    while (cyc < 500) step(cyc);
    rst_n = 1'b0;
    #1;
    total++;
    if ({op_a, op_b, op_code, alu_ena, busy, done, pass, err_count, first_fail, fail_seen, dbg_state} !== '0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b ena=%b state=%0d, want all zero", busy, alu_ena, dbg_state);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, dbg_state} !== 4'd0) begin
      bad++;
      $display("FAIL reset_hold: got busy=%b done=%b state=%0d, want 0 0 0", busy, done, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model_report(0));
    pulse_start();
    wait_done(1, dc, lb);
    e = exp_q.pop_front();
    total++;
    if (dc != 2050 || observed() !== e) begin
      bad++;
      $display("FAIL post_reset_run: got done@%0d %h, want done@2050 %h", dc, observed(), e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_clean_pass();
    test_flip_vector5();
    test_carry_stuck();
    test_res_stuck();
    test_ignore_start();
    test_restart_from_done();
    test_reset_mid_sweep();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
